// File: rtl/thunderbird_seq.sv
// Purpose: tail-light sequencer; sweeps LAMPS lamps per side, with optional hazard blink.
// Latency: registered Moore outputs; a request is acted on at the next prescaler tick (<= DIV cycles).
// Backpressure: none; lamp drivers have no handshake and the sequence never stalls.
//
// Parameters: LAMPS (1..16) lamps per side, DIV (1..65535) clock cycles per step.
// Ports: Clk/Rs_n clock and async active-low reset; L/R level turn requests;
//        LT/RT lamp banks (bit 0 = innermost lamp); Busy high while not IDLE.
// Build option: define THUNDERBIRD_HAZARD_EN to enable the both-sides hazard state.
module thunderbird_seq #(
    parameter int LAMPS = 3,
    parameter int DIV   = 1
) (
    input  logic             Clk,
    input  logic             Rs_n,
    input  logic             L,
    input  logic             R,
    output logic [LAMPS-1:0] LT,
    output logic [LAMPS-1:0] RT,
    output logic             Busy
);

    localparam int PCW = (DIV <= 1) ? 1 : $clog2(DIV);
    localparam int KW  = $clog2(LAMPS + 1);

`ifdef THUNDERBIRD_HAZARD_EN
    typedef enum logic [1:0] {IDLE, LEFT, RIGHT, HAZ} state_t;
`else
    typedef enum logic [1:0] {IDLE, LEFT, RIGHT} state_t;
`endif

    logic [PCW-1:0]   pc;
    logic             tick;
    state_t           state_q, state_d;
    logic [KW-1:0]    k_q, k_d;
    logic [LAMPS-1:0] lt_d, rt_d;
    logic             busy_d;

    // Thermometer fill: lamps 0..n-1 lit, i.e. (1<<n)-1 without overflowing at n==LAMPS.
    function automatic logic [LAMPS-1:0] fill(input logic [KW-1:0] n);
        logic [LAMPS-1:0] m;
        m = '0;
        for (int i = 0; i < LAMPS; i++) begin
            m[i] = (i < int'(n));
        end
        return m;
    endfunction

    // Free-running step prescaler; with DIV=1 it sits at 0 and tick is always high.
    always_ff @(posedge Clk or negedge Rs_n) begin
        if (!Rs_n) begin
            pc <= '0;
        end else if (tick) begin
            pc <= '0;
        end else begin
            pc <= pc + PCW'(1);
        end
    end

    assign tick = (pc == PCW'(DIV - 1));

    always_ff @(posedge Clk or negedge Rs_n) begin
        if (!Rs_n) begin
            state_q <= IDLE;
            k_q     <= '0;
            LT      <= '0;
            RT      <= '0;
            Busy    <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            LT      <= lt_d;
            RT      <= rt_d;
            Busy    <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        lt_d    = '0;
        rt_d    = '0;
        busy_d  = 1'b0;

        // Requests are only looked at on tick edges; between ticks everything holds.
        if (tick) begin
            case (state_q)
                IDLE: begin
                    if (L && !R) begin
                        state_d = LEFT;
                        k_d     = KW'(1);
                    end else if (!L && R) begin
                        state_d = RIGHT;
                        k_d     = KW'(1);
                    end
`ifdef THUNDERBIRD_HAZARD_EN
                    else if (L && R) begin
                        state_d = HAZ;
                        k_d     = '0;
                    end
`endif
                end
                // Sweeps run to completion regardless of L/R; the return to IDLE
                // guarantees a dark step before any new sequence.
                LEFT, RIGHT: begin
                    if (k_q == KW'(LAMPS)) begin
                        state_d = IDLE;
                        k_d     = '0;
                    end else begin
                        k_d = k_q + KW'(1);
                    end
                end
`ifdef THUNDERBIRD_HAZARD_EN
                HAZ: begin
                    state_d = IDLE;
                    k_d     = '0;
                end
`endif
                default: begin
                    state_d = IDLE;
                    k_d     = '0;
                end
            endcase
        end

        // Outputs decoded from the next state so they register on the same edge.
        case (state_d)
            LEFT:    lt_d = fill(k_d);
            RIGHT:   rt_d = fill(k_d);
`ifdef THUNDERBIRD_HAZARD_EN
            HAZ: begin
                lt_d = '1;
                rt_d = '1;
            end
`endif
            default: begin
                lt_d = '0;
                rt_d = '0;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

endmodule

// File: tb/tb_thunderbird_seq.sv
module tb_thunderbird_seq;

    logic       Clk;
    logic       Rs_n;

    // u0: LAMPS=3, DIV=1
    logic       L0, R0;
    logic [2:0] LT0, RT0;
    logic       Busy0;
    // u1: LAMPS=5, DIV=4
    logic       L1, R1;
    logic [4:0] LT1, RT1;
    logic       Busy1;
    // u2: LAMPS=3, DIV=2
    logic       L2, R2;
    logic [2:0] LT2, RT2;
    logic       Busy2;

    int tests = 0;
    int fails = 0;

    thunderbird_seq #(.LAMPS(3), .DIV(1)) u0 (
        .Clk(Clk), .Rs_n(Rs_n), .L(L0), .R(R0), .LT(LT0), .RT(RT0), .Busy(Busy0)
    );
    thunderbird_seq #(.LAMPS(5), .DIV(4)) u1 (
        .Clk(Clk), .Rs_n(Rs_n), .L(L1), .R(R1), .LT(LT1), .RT(RT1), .Busy(Busy1)
    );
    thunderbird_seq #(.LAMPS(3), .DIV(2)) u2 (
        .Clk(Clk), .Rs_n(Rs_n), .L(L2), .R(R2), .LT(LT2), .RT(RT2), .Busy(Busy2)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk3(input string name, input logic [2:0] lt, input logic [2:0] rt,
                        input logic busy, input logic [2:0] elt, input logic [2:0] ert,
                        input logic ebusy);
        tests++;
        if (lt !== elt || rt !== ert || busy !== ebusy) begin
            fails++;
            $display("FAIL %s: got LT=%b RT=%b Busy=%b, expected LT=%b RT=%b Busy=%b",
                     name, lt, rt, busy, elt, ert, ebusy);
        end
    endtask

    task automatic test_reset();
        Rs_n = 1'b0;
        L0 = 0; R0 = 0; L1 = 0; R1 = 0; L2 = 0; R2 = 0;
        #1;
        chk3("reset_initial", LT0, RT0, Busy0, 3'b000, 3'b000, 1'b0);
        @(negedge Clk);
        Rs_n = 1'b1;
        step();
        chk3("reset_idle", LT0, RT0, Busy0, 3'b000, 3'b000, 1'b0);
        // Start a left sweep and reset it at k=2.
        L0 = 1'b1;
        step();
        chk3("reset_pre_k1", LT0, RT0, Busy0, 3'b001, 3'b000, 1'b1);
        step();
        chk3("reset_pre_k2", LT0, RT0, Busy0, 3'b011, 3'b000, 1'b1);
        Rs_n = 1'b0;
        #1;
        chk3("reset_async_clear", LT0, RT0, Busy0, 3'b000, 3'b000, 1'b0);
        L0 = 1'b0;
        #1;
        Rs_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk3("reset_after_release", LT0, RT0, Busy0, 3'b000, 3'b000, 1'b0);
        end
    endtask

    task automatic test_left_sweep();
        logic [2:0] exp_lt [0:3];
        exp_lt[0] = 3'b001; exp_lt[1] = 3'b011; exp_lt[2] = 3'b111; exp_lt[3] = 3'b000;
        L0 = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            chk3("left_sweep", LT0, RT0, Busy0, exp_lt[i % 4], 3'b000, (i % 4) != 3);
        end
        L0 = 1'b0;
        step();
        chk3("left_release_idle", LT0, RT0, Busy0, 3'b000, 3'b000, 1'b0);
    endtask

    task automatic test_non_interruptible();
        L0 = 1'b1;
        step();
        chk3("nonint_l1", LT0, RT0, Busy0, 3'b001, 3'b000, 1'b1);
        L0 = 1'b0;
        R0 = 1'b1;
        step();
        chk3("nonint_l2", LT0, RT0, Busy0, 3'b011, 3'b000, 1'b1);
        step();
        chk3("nonint_l3", LT0, RT0, Busy0, 3'b111, 3'b000, 1'b1);
        step();
        chk3("nonint_dark", LT0, RT0, Busy0, 3'b000, 3'b000, 1'b0);
        step();
        chk3("nonint_r1", LT0, RT0, Busy0, 3'b000, 3'b001, 1'b1);
        R0 = 1'b0;
        step();
        chk3("nonint_r2", LT0, RT0, Busy0, 3'b000, 3'b011, 1'b1);
        step();
        chk3("nonint_r3", LT0, RT0, Busy0, 3'b000, 3'b111, 1'b1);
        step();
        chk3("nonint_r_dark", LT0, RT0, Busy0, 3'b000, 3'b000, 1'b0);
    endtask

    task automatic test_right_prescaled();
        bit         found;
        logic [4:0] exp_rt;
        int         st;
        found = 0;
        R1 = 1'b1;
        // First lamp must appear within DIV cycles.
        for (int i = 0; i < 4; i++) begin
            step();
            if (RT1 !== 5'b00000) begin
                found = 1;
                break;
            end
        end
        tests++;
        if (!found) begin
            fails++;
            $display("FAIL right_latency: RT=%b still dark after 4 cycles, expected 00001", RT1);
        end else begin
            for (int i = 0; i < 24; i++) begin
                if (i != 0) step();
                st = i / 4;
                exp_rt = (st < 5) ? 5'((1 << (st + 1)) - 1) : 5'b00000;
                tests++;
                if (RT1 !== exp_rt || LT1 !== 5'b00000 || Busy1 !== (st < 5)) begin
                    fails++;
                    $display("FAIL right_prescaled cycle %0d: got RT=%b LT=%b Busy=%b, expected RT=%b LT=00000 Busy=%b",
                             i, RT1, LT1, Busy1, exp_rt, (st < 5));
                end
            end
        end
        R1 = 1'b0;
    endtask

    task automatic test_hazard();
        L2 = 1'b1;
        R2 = 1'b1;
`ifdef THUNDERBIRD_HAZARD_EN
        begin
            bit         found;
            logic [2:0] e;
            found = 0;
            for (int i = 0; i < 2; i++) begin
                step();
                if (LT2 !== 3'b000) begin
                    found = 1;
                    break;
                end
            end
            tests++;
            if (!found) begin
                fails++;
                $display("FAIL hazard_latency: LT=%b still dark after 2 cycles, expected 111", LT2);
            end else begin
                for (int i = 0; i < 8; i++) begin
                    if (i != 0) step();
                    e = (((i / 2) % 2) == 0) ? 3'b111 : 3'b000;
                    chk3("hazard_blink", LT2, RT2, Busy2, e, e, e[0]);
                end
            end
        end
`else
        for (int i = 0; i < 12; i++) begin
            step();
            chk3("hazard_disabled", LT2, RT2, Busy2, 3'b000, 3'b000, 1'b0);
        end
`endif
        L2 = 1'b0;
        R2 = 1'b0;
    endtask

    initial begin
        test_reset();
        test_left_sweep();
        test_non_interruptible();
        test_right_prescaled();
        test_hazard();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
